// File: rtl/ecc_point_link.sv
// Initiator link for the ECC point interface: sends a four-point batch as two
// strobed beats, then gathers two result beats into a bytewise-readable word.
module ecc_point_link #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 31
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [4*WIDTH-1:0] px_in,
    input  logic [4*WIDTH-1:0] py_in,
    output logic               s0,
    output logic [WIDTH-1:0]   x_out1,
    output logic [WIDTH-1:0]   y_out1,
    output logic [WIDTH-1:0]   x_out2,
    output logic [WIDTH-1:0]   y_out2,
    input  logic               valid,
    input  logic [WIDTH-1:0]   x_in,
    input  logic [WIDTH-1:0]   y_in,
    input  logic [1:0]         sel,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               result_valid
);

    typedef enum logic [2:0] {
        IDLE, SEND0, SEND1, WAIT0, WAIT1, DONE, ERR
    } state_t;

    localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [4*WIDTH-1:0] px_q, px_d;
    logic [4*WIDTH-1:0] py_q, py_d;
    logic [4*WIDTH-1:0] res_q, res_d;
    logic [7:0]         tmr_q, tmr_d;
    logic               rv_q, rv_d;

    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        res_d   = res_q;
        tmr_d   = tmr_q;
        rv_d    = rv_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    px_d    = px_in;
                    py_d    = py_in;
                    res_d   = '0;
                    rv_d    = 1'b0;
                    state_d = SEND0;
                end
            end
            SEND0: state_d = SEND1;
            SEND1: begin
                tmr_d   = '0;
                state_d = WAIT0;
            end
            WAIT0: begin
                tmr_d = tmr_q + 8'd1;
                if (valid) begin
                    res_d[0*WIDTH +: WIDTH] = x_in;
                    res_d[1*WIDTH +: WIDTH] = y_in;
                    state_d = WAIT1;
                end else if (tmr_q == TLIM) begin
                    state_d = ERR;
                end
            end
            WAIT1: begin
                tmr_d = tmr_q + 8'd1;
                if (valid) begin
                    res_d[2*WIDTH +: WIDTH] = x_in;
                    res_d[3*WIDTH +: WIDTH] = y_in;
                    // flag rises together with the done pulse
                    rv_d    = 1'b1;
                    state_d = DONE;
                end else if (tmr_q == TLIM) begin
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            px_q    <= '0;
            py_q    <= '0;
            res_q   <= '0;
            tmr_q   <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            res_q   <= res_d;
            tmr_q   <= tmr_d;
            rv_q    <= rv_d;
        end
    end

    always_comb begin
        x_out1 = '0;
        y_out1 = '0;
        x_out2 = '0;
        y_out2 = '0;
        if (state_q == SEND0) begin
            x_out1 = px_q[0*WIDTH +: WIDTH];
            y_out1 = py_q[0*WIDTH +: WIDTH];
            x_out2 = px_q[1*WIDTH +: WIDTH];
            y_out2 = py_q[1*WIDTH +: WIDTH];
        end else if (state_q == SEND1) begin
            x_out1 = px_q[2*WIDTH +: WIDTH];
            y_out1 = py_q[2*WIDTH +: WIDTH];
            x_out2 = px_q[3*WIDTH +: WIDTH];
            y_out2 = py_q[3*WIDTH +: WIDTH];
        end
    end

    assign s0           = (state_q == SEND0) || (state_q == SEND1);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign err          = (state_q == ERR);
    assign result_valid = rv_q;
    assign data_out     = res_q[32'(sel) * WIDTH +: WIDTH];

endmodule

// File: tb/tb_ecc_point_link.sv
// Directed bench for ecc_point_link: beats, result collection, gaps,
// timeout, timeout tie and asynchronous reset mid-transfer.
module tb_ecc_point_link;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] px_in, py_in;
    logic        s0;
    logic [7:0]  x_out1, y_out1, x_out2, y_out2;
    logic        valid;
    logic [7:0]  x_in, y_in;
    logic [1:0]  sel;
    logic [7:0]  data_out;
    logic        busy, done, err, result_valid;

    int errors = 0;
    int checks = 0;

    ecc_point_link #(.WIDTH(8), .TIMEOUT(31)) dut (
        .clk(clk), .reset(reset), .start(start),
        .px_in(px_in), .py_in(py_in),
        .s0(s0), .x_out1(x_out1), .y_out1(y_out1),
        .x_out2(x_out2), .y_out2(y_out2),
        .valid(valid), .x_in(x_in), .y_in(y_in),
        .sel(sel), .data_out(data_out),
        .busy(busy), .done(done), .err(err),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pts(input string tag, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d);
        check({tag, "_x1"}, x_out1, a);
        check({tag, "_y1"}, y_out1, b);
        check({tag, "_x2"}, x_out2, c);
        check({tag, "_y2"}, y_out2, d);
    endtask

    task automatic chk_res(input string tag, input logic [31:0] exp);
        logic [31:0] e;
        e = exp;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #1;
            check($sformatf("%s_sel%0d", tag, i), data_out, e[8*i +: 8]);
        end
        sel = 2'd0;
    endtask

    task automatic beat(input logic [7:0] x, input logic [7:0] y);
        valid = 1'b1;
        x_in  = x;
        y_in  = y;
    endtask

    task automatic send(input logic [31:0] px, input logic [31:0] py);
        start = 1'b1;
        px_in = px;
        py_in = py;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        px_in = '0;
        py_in = '0;
        valid = 1'b0;
        x_in  = '0;
        y_in  = '0;
        sel   = 2'd0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_s0", s0, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rv", result_valid, 0);
        check("rst_x1", x_out1, 0);
        chk_res("rst_res", 32'h0);
        reset = 1'b0;
        tick();

        // basic transfer and result collection
        send(32'h44332211, 32'h88776655);
        check("b_s0_c1", s0, 1);
        check("b_busy_c1", busy, 1);
        chk_pts("b_c1", 8'h11, 8'h55, 8'h22, 8'h66);
        tick();
        check("b_s0_c2", s0, 1);
        chk_pts("b_c2", 8'h33, 8'h77, 8'h44, 8'h88);
        tick();
        check("b_s0_c3", s0, 0);
        chk_pts("b_c3", 8'h00, 8'h00, 8'h00, 8'h00);
        beat(8'hA0, 8'hB1);
        tick();
        beat(8'hC2, 8'hD3);
        tick();
        valid = 1'b0;
        check("b_done_c5", done, 1);
        check("b_rv_c5", result_valid, 1);
        chk_res("b_res", 32'hD3C2B1A0);
        tick();
        check("b_busy_c6", busy, 0);
        check("b_done_c6", done, 0);
        check("b_rv_c6", result_valid, 1);

        // gapped beats, ignored valid and start; starts at earliest cycle
        send(32'h0D0C0B0A, 32'h1D1C1B1A);
        check("g_s0_c1", s0, 1);
        check("g_rv_c1", result_valid, 0);
        chk_res("g_clr", 32'h0);
        beat(8'hEE, 8'hEE);
        tick();
        valid = 1'b0;
        chk_pts("g_c2", 8'h0C, 8'h1C, 8'h0D, 8'h1D);
        repeat (5) tick();
        check("g_busy_c7", busy, 1);
        beat(8'h5A, 8'h6B);
        tick();
        valid = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("g_s0_c10", s0, 0);
        check("g_busy_c10", busy, 1);
        tick();
        tick();
        beat(8'h7C, 8'h8D);
        tick();
        valid = 1'b0;
        check("g_done_c13", done, 1);
        chk_res("g_res", 32'h8D7C6B5A);
        tick();
        check("g_busy_c14", busy, 0);
        check("g_s0_c14", s0, 0);
        tick();

        // timeout after a single beat
        send(32'h1, 32'h2);
        repeat (4) tick();
        beat(8'h31, 8'h42);
        tick();
        valid = 1'b0;
        repeat (27) tick();
        check("t_err_c33", err, 0);
        check("t_busy_c33", busy, 1);
        tick();
        check("t_err_c34", err, 1);
        check("t_done_c34", done, 0);
        check("t_rv_c34", result_valid, 0);
        chk_res("t_part", 32'h00004231);
        tick();
        check("t_busy_c35", busy, 0);
        check("t_err_c35", err, 0);
        tick();

        // second beat lands on the last timer value
        send(32'h3, 32'h4);
        tick();
        tick();
        beat(8'h01, 8'h23);
        tick();
        valid = 1'b0;
        repeat (29) tick();
        beat(8'h45, 8'h67);
        tick();
        valid = 1'b0;
        check("tie_done_c34", done, 1);
        check("tie_err_c34", err, 0);
        check("tie_rv_c34", result_valid, 1);
        chk_res("tie_res", 32'h67452301);
        tick();
        check("tie_err_c35", err, 0);
        tick();

        // asynchronous reset in WAIT1
        send(32'h55555555, 32'h66666666);
        tick();
        tick();
        beat(8'hAB, 8'hCD);
        tick();
        valid = 1'b0;
        check("r_busy_c4", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("r_busy", busy, 0);
        check("r_s0", s0, 0);
        check("r_rv", result_valid, 0);
        chk_res("r_res", 32'h0);
        #1;
        reset = 1'b0;
        tick();
        check("r_idle", busy, 0);
        check("r_done", done, 0);
        send(32'h44332211, 32'h88776655);
        check("r_s0_c1", s0, 1);
        chk_pts("r_c1", 8'h11, 8'h55, 8'h22, 8'h66);
        tick();
        chk_pts("r_c2", 8'h33, 8'h77, 8'h44, 8'h88);
        tick();
        check("r_s0_c3", s0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ecc_point_link.md
# ecc_point_link

Initiator-side link for the ECC point interface. It takes a four-point batch (packed x and y coordinates) and transmits it as two strobed beats of two points each. It then collects the two returned result beats (x/y pairs qualified by `valid`) into a 32-bit result word that can be read back bytewise. It sits between the host/test controller and the ECC top, driving that block's point-load port and receiving its result port.

## Interface
- `WIDTH`, default 8: coordinate width; the packed buses are 4*WIDTH bits.
- `TIMEOUT`, default 31: maximum cycles spent waiting for both result beats; legal range is 2..255.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a transfer; sampled only in IDLE.
- `px_in`  in  4*WIDTH  x coordinates; byte i is point i.
- `py_in`  in  4*WIDTH  y coordinates; byte i is point i.
- `s0`  out  1  beat strobe for the point load.
- `x_out1`, `y_out1`  out  WIDTH  first point of the current beat.
- `x_out2`, `y_out2`  out  WIDTH  second point of the current beat.
- `valid`  in  1  result beat qualifier from the responder.
- `x_in`, `y_in`  in  WIDTH  result pair for the current beat.
- `sel`  in  2  byte select for `data_out`.
- `data_out`  out  WIDTH  selected byte of the result (combinational).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the result is complete.
- `err`  out  1  one-cycle pulse on timeout.
- `result_valid`  out  1  sticky flag: result register holds a complete result.

## Operation
- FSM states: IDLE, SEND0, SEND1, WAIT0, WAIT1, DONE, ERR. All outputs except `data_out` are registered or decoded from state only.
- **IDLE**
  - On `start=1`: latch `px_in`/`py_in`, clear `result_valid` and the result register, go to SEND0.
- **SEND0**
  - `s0=1`; `x_out1=px[0]`, `y_out1=py[0]`, `x_out2=px[1]`, `y_out2=py[1]` (index = byte).
  - Next state SEND1.
- **SEND1**
  - `s0=1`; points 2 and 3 on the same ports.
  - Clear the timer; next state WAIT0.
- **WAIT0**
  - On `valid`: result[7:0]←`x_in`, result[15:8]←`y_in`; go to WAIT1.
- **WAIT1**
  - On `valid`: result[23:16]←`x_in`, result[31:24]←`y_in`; go to DONE.
- **Timer**
  - Increments every cycle in WAIT0/WAIT1 and is not cleared between them (total budget).
  - If the timer equals TIMEOUT-1 and `valid=0`, go to ERR.
  - `valid` takes priority over the timeout in the same cycle.
- **DONE**: `done=1`, set `result_valid`; go to IDLE.
- **ERR**: `err=1`; `result_valid` stays 0, the partial result is retained; go to IDLE.
- **Ignored inputs**
  - `start` is ignored outside IDLE.
  - `valid` is ignored outside WAIT0/WAIT1, including during SEND0/SEND1.
- **Point outputs**: `x_out*`/`y_out*` are 0 whenever `s0=0`.
- **Readback**: `data_out = result[8*sel+7 : 8*sel]`; the result register holds until the next accepted `start`.
- **Width**: WIDTH≠8 scales the byte slots to WIDTH-bit slots.

## Timing
- Cycle n is the interval after rising edge n; `start` is sampled at edge 0.
- **Reset**
  - Asynchronous: FSM goes to IDLE immediately.
  - Every output, latched point, the timer and the result register are cleared to 0.
  - Applies mid-transfer too; no beat or pulse completes after reset.
- **Send latency**: SEND0 in cycle 1, SEND1 in cycle 2, so `s0` is high for exactly cycles 1–2 (two consecutive beats).
- **Minimum round trip**: WAIT0 in cycle 3. With `valid` sampled at edges 3 and 4, DONE is in cycle 5: `done=1`, and `result_valid=1` from cycle 5.
- **Earliest next transfer**: `busy` falls in cycle 6; a `start` sampled at edge 6 begins the next transfer.
- **Timeout**: WAIT0+WAIT1 last at most TIMEOUT cycles. With no `valid`, `err` pulses in cycle 3+TIMEOUT (34 at the default).
- **Gaps between beats**: `valid` may be non-contiguous. Gaps between the two beats consume the shared timer.

## Test plan
- Basic transfer
  - Stimulus: `px_in=32'h44332211`, `py_in=32'h88776655`, `start` at edge 0.
  - Required: cycle 1 `s0=1` with (11,55),(22,66); cycle 2 with (33,77),(44,88); cycle 3 `s0=0` and all point outputs 0.
- Result collection
  - Stimulus: basic transfer, then `valid` with (A0,B1) at edge 3 and (C2,D3) at edge 4.
  - Required: `done` and `result_valid` in cycle 5. `data_out` for `sel`=0..3 reads A0, B1, C2, D3.
- Gapped beats and ignored inputs
  - Stimulus: `valid` asserted during cycle 1 (ignored); beats at edges 7 and 12; `start` pulsed at edge 9.
  - Required: result as above, `done` in cycle 13, the `start` at edge 9 has no effect.
- Timeout
  - Stimulus: TIMEOUT=31, only one beat at edge 5.
  - Required: `err` in cycle 34, no `done`, `result_valid=0`, `busy=0` in cycle 35.
- Timeout tie
  - Stimulus: second beat arrives exactly when the timer equals TIMEOUT-1.
  - Required: DONE wins and `err` stays 0.
- Reset mid-operation
  - Stimulus: assert `reset` between edges in cycle 4 (WAIT1), asynchronously.
  - Required: all outputs 0 before the next edge; after release, a new transfer behaves as in the basic transfer scenario.
